lab2_proc_mem_responder: RTL



---
 rtl/lab2_proc_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lab2_proc_mem_responder.sv
// lab2_proc_mem_responder
// Fixed-latency test memory for one processor memory port (imem or dmem).
// Each accepted request is served against an internal word array in the
// acceptance cycle. Its response is parked in a 2-entry FIFO and returned in
// request order.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   reqstream_*     - val/rdy request stream carrying mem_req_4B_t
//   respstream_*    - val/rdy response stream carrying mem_resp_4B_t
// Parameter:
//   p_num_words     - array depth in 32-bit words (power of two, >= 4)

package lab2_proc_mem_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

module lab2_proc_mem_responder
  import lab2_proc_mem_pkg::*;
#(
  parameter int p_num_words = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reqstream_val,
  output logic         reqstream_rdy,
  input  mem_req_4B_t  reqstream_msg,
  output logic         respstream_val,
  input  logic         respstream_rdy,
  output mem_resp_4B_t respstream_msg
);

  localparam int IDX_W = $clog2(p_num_words);

  // Active byte lanes: off .. off+nbytes-1. Lanes past byte 3 are dropped.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] len);
    logic [2:0] nb;
    logic [3:0] m;
    nb = (len == 2'd0) ? 3'd4 : {1'b0, len};
    m  = '0;
    for (int b = 0; b < 4; b++) begin
      if ((3'(b) >= {1'b0, off}) && (3'(b) < ({1'b0, off} + nb)))
        m[b] = 1'b1;
    end
    return m;
  endfunction

  // Shift the addressed bytes down to lane 0 and zero everything above nbytes.
  function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] len);
    logic [2:0]  nb;
    logic [31:0] sh;
    nb = (len == 2'd0) ? 3'd4 : {1'b0, len};
    sh = word >> {off, 3'b000};
    for (int i = 0; i < 4; i++) begin
      if (3'(i) >= nb)
        sh[8*i +: 8] = 8'h00;
    end
    return sh;
  endfunction

  function automatic logic [31:0] write_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] off, input logic [1:0] len);
    logic [31:0] wsh;
    logic [31:0] res;
    logic [3:0]  m;
    wsh = data << {off, 3'b000};
    m   = lane_mask(off, len);
    res = word;
    for (int b = 0; b < 4; b++) begin
      if (m[b])
        res[8*b +: 8] = wsh[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] mem [p_num_words];

  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  mem_resp_4B_t q_p1 [2];

  logic               accept;
  logic               consume;
  logic [IDX_W-1:0]   idx_p0;
  logic [31:0]        word_p0;
  logic [31:0]        wdata_p0;
  logic               wr_en_p0;
  mem_resp_4B_t       resp_p0;

  // Address bits above the array index wrap the address space.
  logic unused_addr_hi;
  assign unused_addr_hi = ^reqstream_msg.addr[31:IDX_W+2];

  assign reqstream_rdy  = !reset && (count < 2'd2);
  assign respstream_val = !reset && (count != 2'd0);
  assign accept         = reqstream_val && reqstream_rdy;
  assign consume        = respstream_val && respstream_rdy;

  // Stage p0: array access in the acceptance cycle
  always_comb begin
    idx_p0         = reqstream_msg.addr[2 +: IDX_W];
    word_p0        = mem[idx_p0];
    wdata_p0       = write_merge(word_p0, reqstream_msg.data, reqstream_msg.addr[1:0],
                                 reqstream_msg.len);
    wr_en_p0       = accept && ((reqstream_msg.type_ == 3'd1) || (reqstream_msg.type_ == 3'd2));
    resp_p0        = '0;
    resp_p0.type_  = reqstream_msg.type_;
    resp_p0.opaque = reqstream_msg.opaque;
    resp_p0.len    = reqstream_msg.len;
    if (reqstream_msg.type_ == 3'd0)
      resp_p0.data = read_align(word_p0, reqstream_msg.addr[1:0], reqstream_msg.len);
  end

  always_ff @(posedge clk) begin
    if (wr_en_p0)
      mem[idx_p0] <= wdata_p0;
  end

  // Stage p1: response FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= ~wr_ptr;
      if (consume)
        rd_ptr <= ~rd_ptr;
      case ({accept, consume})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      q_p1[wr_ptr] <= resp_p0;
  end

  // Entries are not reset, so the head is masked while the queue is empty.
  assign respstream_msg = respstream_val ? q_p1[rd_ptr] : '0;

endmodule
